mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative signed multiply/divide unit for the multicycle CPU. It consumes the control unit's `mult_start`/`div_start` pulses and computes MIPS `mult`/`div` over multiple cycles. It exposes separate HI/LO result pairs per operation, selected downstream by `HiLoSrc` before `HI_write`/`LO_write`. It returns a one-cycle `done` pulse and a `divzero` flag for the control unit's exception path.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Product and result pairs are 2×WIDTH.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `mult_start`  in  1  start signed multiply; sampled only in IDLE.
- `div_start`  in  1  start signed divide; sampled only in IDLE.
- `a`  in  WIDTH  operand A: multiplicand or dividend (register A).
- `b`  in  WIDTH  operand B: multiplier or divisor (register B).
- `mult_hi`  out  WIDTH  upper half of product.
- `mult_lo`  out  WIDTH  lower half of product.
- `div_hi`  out  WIDTH  remainder.
- `div_lo`  out  WIDTH  quotient.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle completion pulse.
- `divzero`  out  1  one-cycle pulse on divide by zero.

## Operation

- States: IDLE, MULT, DIV, DONE.
- **IDLE:**
  - On `mult_start`, latch `a` and `b`, clear the counter, go to MULT.
  - On `div_start` with `b != 0`, latch |a| and |b| plus both sign bits, go to DIV.
  - On `div_start` with `b == 0`, go to DONE with `divzero` pending. No iteration; `div_hi`/`div_lo` unchanged.
  - `mult_start` has priority when both starts are high; `div_start` is then ignored.
- **MULT:** radix-2 Booth.
  - Register is {acc[WIDTH], q[WIDTH], q_1}.
  - Each cycle: add or subtract the multiplicand per {q[0], q_1}, then arithmetic-shift the 2W+1 register right by 1.
  - Runs WIDTH cycles, then goes to DONE.
- **DIV:** unsigned restoring division on magnitudes.
  - Each cycle: shift {rem, quo} left by 1; if rem ≥ |b|, subtract and set quo[0].
  - Runs WIDTH cycles, then goes to DONE.
- **DONE:** write the result pair of the active operation, pulse `done`, return to IDLE.
  - Divide sign fix is applied at this write: quotient negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Arithmetic is modulo 2^WIDTH per half.
  - -2^31 / -1 yields quo 0x80000000, rem 0. No overflow flag.
- Only the active operation's pair is updated. The other pair holds its value.
- `start` pulses while `busy` are ignored.
- Reset mid-operation aborts: state goes to IDLE, no `done`, all outputs cleared.

## Timing

- Reset values: `mult_hi`, `mult_lo`, `div_hi`, `div_lo` = 0; `busy` = 0; `done` = 0; `divzero` = 0; state IDLE.
- Call the start-sampling edge k.
  - `busy` is high from k to edge k+WIDTH+1.
  - Iterations occur on edges k+1..k+WIDTH.
  - Results and `done` are registered on edge k+WIDTH+1.
  - `done` is high for exactly that one cycle; results are valid in that cycle and hold afterward.
- Latency is 33 cycles for both mult and div at WIDTH=32.
- Divide by zero: `divzero` and `done` are both high for the one cycle after edge k+1. `busy` is high only for the cycle after edge k.
- A new start is accepted in the cycle `done` is high, since the state is then IDLE.

## Structure

- Shared package `cpu_pkg`:
  - `md_state_t` enum (IDLE, MULT, DIV, DONE).
  - `WORD_W` = 32.
  - Shift-amount constant `MD_ITER` = WORD_W.
- Single module. MULT and DIV share one iteration counter and one 2W+1 working register; no sub-module is needed.

## Test plan

- Mult a=7, b=0xFFFFFFFD (-3) → `mult_hi`=0xFFFFFFFF, `mult_lo`=0xFFFFFFEB, `done` exactly 33 cycles after start, `div_hi`/`div_lo` unchanged.
- Mult a=b=0x80000000 → `mult_hi`=0x40000000, `mult_lo`=0x00000000.
- Div a=0xFFFFFFF9 (-7), b=2 → `div_lo`=0xFFFFFFFD, `div_hi`=0xFFFFFFFF. Div a=7, b=0xFFFFFFFE → `div_lo`=0xFFFFFFFD, `div_hi`=1.
- Div a=0x80000000, b=0xFFFFFFFF → `div_lo`=0x80000000, `div_hi`=0.
- Div a=5, b=0 → `divzero`=`done`=1 for one cycle at k+1, `busy` one cycle, result pairs unchanged.
- Protocol checks:
  - `mult_start` and `div_start` both high → multiply only.
  - `div_start` pulse at cycle 10 of a mult → ignored.
  - Reset at iteration 10 → all outputs 0, no `done`.
  - A subsequent mult 3×4 → `mult_lo`=12 after 33 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: word width, iteration count and the state
// encoding of the multiply/divide unit.
package cpu_pkg;

   localparam int WORD_W  = 32;
   // Iterations per mult/div: one result bit per cycle.
   localparam int MD_ITER = WORD_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit (MIPS mult/div).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mult_start, div_start start pulses, sampled only while idle
//                         (mult_start wins if both are high)
//   a, b                  operands: multiplicand/dividend, multiplier/divisor
//   mult_hi, mult_lo      product pair, updated only by a multiply
//   div_hi, div_lo        remainder/quotient pair, updated only by a divide
//   busy                  high while an operation is in progress
//   done                  one-cycle completion pulse
//   divzero               one-cycle pulse (with done) on divide by zero
//
// Handshake: a start is accepted only on an edge where busy is low; while
// busy, starts are ignored. Results are valid in the done cycle and hold
// until the next operation of the same kind.
import cpu_pkg::*;

module mult_div_unit #(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic             div_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] mult_hi,
   output logic [WIDTH-1:0] mult_lo,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo,
   output logic             busy,
   output logic             done,
   output logic             divzero
);

   localparam int               CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   md_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // MULT: {acc, q, q_1}. DIV: {rem (W+1 bits), quo}.
   logic [2*WIDTH:0]   work_q, work_d;
   // Multiplicand (MULT) or divisor magnitude (DIV).
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               is_div_q, is_div_d;
   logic               dz_pend_q, dz_pend_d;
   logic [WIDTH-1:0]   mult_hi_q, mult_hi_d;
   logic [WIDTH-1:0]   mult_lo_q, mult_lo_d;
   logic [WIDTH-1:0]   div_hi_q, div_hi_d;
   logic [WIDTH-1:0]   div_lo_q, div_lo_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;

   // Booth step datapath. The sum is kept one bit wider so that subtracting
   // the most negative multiplicand cannot overflow before the shift.
   logic [WIDTH:0]     acc_x, mcand_x, booth_sum;
   // Restoring division datapath.
   logic [2*WIDTH:0]   div_shift;
   logic [WIDTH:0]     rem_try, rem_diff;
   logic               rem_ge;
   logic [WIDTH-1:0]   a_abs, b_abs, quo, rem;

   always_comb begin
      acc_x   = {work_q[2*WIDTH], work_q[2*WIDTH:WIDTH+1]};
      mcand_x = {mcand_q[WIDTH-1], mcand_q};
      case (work_q[1:0])
         2'b01:   booth_sum = acc_x + mcand_x;
         2'b10:   booth_sum = acc_x - mcand_x;
         default: booth_sum = acc_x;
      endcase

      div_shift = {work_q[2*WIDTH-1:0], 1'b0};
      rem_try   = div_shift[2*WIDTH:WIDTH];
      rem_diff  = rem_try - {1'b0, mcand_q};
      rem_ge    = rem_try >= {1'b0, mcand_q};

      a_abs = a[WIDTH-1] ? -a : a;
      b_abs = b[WIDTH-1] ? -b : b;
      quo   = work_q[WIDTH-1:0];
      rem   = work_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      mcand_d   = mcand_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      is_div_d  = is_div_q;
      dz_pend_d = dz_pend_q;
      mult_hi_d = mult_hi_q;
      mult_lo_d = mult_lo_q;
      div_hi_d  = div_hi_q;
      div_lo_d  = div_lo_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (mult_start) begin
               work_d    = {{WIDTH{1'b0}}, b, 1'b0};
               mcand_d   = a;
               cnt_d     = '0;
               is_div_d  = 1'b0;
               dz_pend_d = 1'b0;
               state_d   = MULT;
            end else if (div_start) begin
               is_div_d = 1'b1;
               if (b == '0) begin
                  dz_pend_d = 1'b1;
                  state_d   = DONE;
               end else begin
                  work_d    = {{(WIDTH+1){1'b0}}, a_abs};
                  mcand_d   = b_abs;
                  sign_a_d  = a[WIDTH-1];
                  sign_b_d  = b[WIDTH-1];
                  cnt_d     = '0;
                  dz_pend_d = 1'b0;
                  state_d   = DIV;
               end
            end
         end
         MULT: begin
            // Add/subtract, then arithmetic shift of the whole register.
            work_d = {booth_sum, work_q[WIDTH:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DIV: begin
            work_d = rem_ge ? {rem_diff, div_shift[WIDTH-1:1], 1'b1} : div_shift;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dz_pend_q) begin
               divzero_d = 1'b1;
            end else if (is_div_q) begin
               // Truncating division: quotient sign from operand signs,
               // remainder sign from the dividend.
               div_lo_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
               div_hi_d = sign_a_q ? -rem : rem;
            end else begin
               mult_hi_d = work_q[2*WIDTH:WIDTH+1];
               mult_lo_d = work_q[WIDTH:1];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         mcand_q   <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         is_div_q  <= 1'b0;
         dz_pend_q <= 1'b0;
         mult_hi_q <= '0;
         mult_lo_q <= '0;
         div_hi_q  <= '0;
         div_lo_q  <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         mcand_q   <= mcand_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         is_div_q  <= is_div_d;
         dz_pend_q <= dz_pend_d;
         mult_hi_q <= mult_hi_d;
         mult_lo_q <= mult_lo_d;
         div_hi_q  <= div_hi_d;
         div_lo_q  <= div_lo_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
      end
   end

   assign mult_hi = mult_hi_q;
   assign mult_lo = mult_lo_q;
   assign div_hi  = div_hi_q;
   assign div_lo  = div_lo_q;
   assign done    = done_q;
   assign divzero = divzero_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors with hand-computed results.
// Drivers push the expected {divzero, mult pair, div pair} on issue; a
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;

   localparam int W     = 32;
   localparam int EXP_W = 1 + 4 * W;

   logic         clk;
   logic         reset;
   logic         mult_start;
   logic         div_start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] mult_hi;
   logic [W-1:0] mult_lo;
   logic [W-1:0] div_hi;
   logic [W-1:0] div_lo;
   logic         busy;
   logic         done;
   logic         divzero;

   int total = 0;
   int bad   = 0;

   logic [EXP_W-1:0] exp_q[$];
   // Bench-side copy of what each result pair should hold.
   logic [W-1:0] m_hi, m_lo, d_hi, d_lo;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .mult_start (mult_start),
      .div_start  (div_start),
      .a          (a),
      .b          (b),
      .mult_hi    (mult_hi),
      .mult_lo    (mult_lo),
      .div_hi     (div_hi),
      .div_lo     (div_lo),
      .busy       (busy),
      .done       (done),
      .divzero    (divzero)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest expected response.
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      if (reset) begin
         done_prev = 1'b0;
      end else begin
         if (done) begin
            if (done_prev) check("done_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("divzero", {31'd0, divzero}, {31'd0, e[4*W]});
               check("mult_hi", mult_hi, e[4*W-1:3*W]);
               check("mult_lo", mult_lo, e[3*W-1:2*W]);
               check("div_hi",  div_hi,  e[2*W-1:W]);
               check("div_lo",  div_lo,  e[W-1:0]);
            end
         end
         done_prev = done;
      end
   end

   // ---------------- driver ----------------
   // Issues one operation, pushes its expectation, then waits (bounded) for
   // done and checks latency and busy. inj pulses a divide-by-zero start
   // 10 cycles into the operation, which must be ignored.
   task automatic run_op(input logic ms, input logic ds,
                         input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic inj, input logic is_div, input logic dz,
                         input logic [W-1:0] r_hi, input logic [W-1:0] r_lo,
                         input int lat);
      int n;
      if (!dz) begin
         if (is_div) begin
            d_hi = r_hi; d_lo = r_lo;
         end else begin
            m_hi = r_hi; m_lo = r_lo;
         end
      end
      exp_q.push_back({dz, m_hi, m_lo, d_hi, d_lo});

      @(negedge clk);
      mult_start = ms;
      div_start  = ds;
      a          = aa;
      b          = bb;
      @(posedge clk);
      #1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      // Operands must already be latched.
      a          = 32'hDEADBEEF;
      b          = 32'h0BADF00D;
      n          = 0;
      while (1) begin
         @(negedge clk);
         div_start = 1'b0;
         if (n == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
         if (done) break;
         if (n > 40) break;
         if (inj && n == 10) begin
            div_start = 1'b1;
            b         = 32'd0;
         end
         @(posedge clk);
         n++;
      end
      check("latency", n, lat);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      div_start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ndone;
      reset      = 1'b1;
      mult_start = 1'b0;
      div_start  = 1'b0;
      a          = '0;
      b          = '0;
      m_hi = '0; m_lo = '0; d_hi = '0; d_lo = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mult_hi", mult_hi, 32'd0);
      check("rst_mult_lo", mult_lo, 32'd0);
      check("rst_div_hi",  div_hi,  32'd0);
      check("rst_div_lo",  div_lo,  32'd0);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_done",    {31'd0, done},    32'd0);
      check("rst_divzero", {31'd0, divzero}, 32'd0);

      //     ms    ds    a             b             inj   div   dz    hi            lo            lat
      run_op(1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
      run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h40000000, 32'h00000000, 33);
      run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op(1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 32'd1,        32'hFFFFFFFD, 33);
      run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'd0,        32'h80000000, 33);
      run_op(1'b0, 1'b1, 32'd100,      32'd7,        1'b0, 1'b1, 1'b0, 32'd2,        32'd14,       33);
      run_op(1'b0, 1'b1, 32'd5,        32'd0,        1'b0, 1'b1, 1'b1, 32'd0,        32'd0,        1);
      // Both starts high: multiply only.
      run_op(1'b1, 1'b1, 32'd3,        32'd5,        1'b0, 1'b0, 1'b0, 32'd0,        32'd15,       33);
      // Divide start mid-multiply must be ignored.
      run_op(1'b1, 1'b0, 32'hFFFFFFFA, 32'd9,        1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFCA, 33);

      // Reset at iteration 10 aborts and clears everything.
      @(negedge clk);
      mult_start = 1'b1;
      a          = 32'd5;
      b          = 32'd5;
      @(posedge clk);
      #1;
      mult_start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0; d_hi = '0; d_lo = '0;
      check("abort_mult_hi", mult_hi, 32'd0);
      check("abort_mult_lo", mult_lo, 32'd0);
      check("abort_div_hi",  div_hi,  32'd0);
      check("abort_div_lo",  div_lo,  32'd0);
      check("abort_busy",    {31'd0, busy}, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);

      run_op(1'b1, 1'b0, 32'd3,        32'd4,        1'b0, 1'b0, 1'b0, 32'd0,        32'd12,       33);

      repeat (3) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net against a hang.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
